// File: rtl/pool_pkg.sv
// Shared types and defaults for the 2x2/stride-2 max-pool scheduler.
// max2 works on a wide word so callers of any data width can share it.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_W  = 8;
  localparam int DEF_H  = 8;
  localparam int DEF_AW = 4;
  localparam int MAX_DW = 64;

  function automatic logic [MAX_DW-1:0] max2(input logic [MAX_DW-1:0] a,
                                             input logic [MAX_DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool2_sched_if.sv
// Stream bundle between the conv engine, the pool scheduler and the feature-map buffer.
// Input side: a sample moves on a rising edge where in_valid && in_ready; out_valid is a one-cycle pulse with no back-pressure.
interface pool2_sched_if #(
   parameter int DW = 16,
   parameter int AW = 4
) ();
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          busy;
   logic          done;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, out_valid, out_data, out_addr, busy, done
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, out_valid, out_data, out_addr, busy, done
   );
endinterface

// File: rtl/pool_line_buf.sv
// One-row line buffer: W entries of DW bits, one write port, one combinational read port.
module pool_line_buf #(
   parameter int DW = 16,
   parameter int W  = 8,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [CW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [CW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Combinational read so the odd-row compare sees lbuf[col] in the accept cycle.
   assign rdata = mem[raddr];
endmodule

// File: rtl/pool2_sched.sv
// 2x2/stride-2 max-pool scheduler: buffers the even row, pools against the odd row,
// emits one max per window with its linear address, and pulses done at frame end.
module pool2_sched
   import pool_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int W  = DEF_W,
   parameter int H  = DEF_H,
   parameter int AW = DEF_AW
) (
   input  logic         clk,
   input  logic         rst_n,
   pool2_sched_if.slave bus,
   output state_t       dbg_state
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [DW-1:0] pmax;
   logic [DW-1:0] lbuf_rd;
   logic [DW-1:0] out_data_q;
   logic [AW-1:0] out_addr_q;
   logic [AW-1:0] win_cnt;
   logic          in_ready_q, out_valid_q, busy_q, done_q;
   logic          accept, lbuf_we, last_col, last_row;

   function automatic logic [DW-1:0] max_dw(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return DW'(max2(MAX_DW'(a), MAX_DW'(b)));
   endfunction

   assign accept   = bus.in_valid & in_ready_q;
   assign lbuf_we  = accept && (state == EVEN_ROW);
   assign last_col = (col == CW'(W - 1));
   assign last_row = (row == RW'(H - 1));

   pool_line_buf #(.DW(DW), .W(W), .CW(CW)) u_lbuf (
      .clk   (clk),
      .we    (lbuf_we),
      .waddr (col),
      .wdata (bus.in_data),
      .raddr (col),
      .rdata (lbuf_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         pmax        <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         win_cnt     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  col        <= '0;
                  row        <= '0;
                  pmax       <= '0;
                  win_cnt    <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= EVEN_ROW;
               end
            end
            EVEN_ROW: begin
               if (accept) begin
                  if (last_col) begin
                     col   <= '0;
                     row   <= row + 1'b1;
                     state <= ODD_ROW;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            ODD_ROW: begin
               if (accept) begin
                  // Even column folds the left pair; odd column closes the window.
                  if (!col[0]) begin
                     pmax <= max_dw(lbuf_rd, bus.in_data);
                  end else begin
                     out_data_q  <= max_dw(pmax, max_dw(lbuf_rd, bus.in_data));
                     out_addr_q  <= win_cnt;
                     win_cnt     <= win_cnt + 1'b1;
                     out_valid_q <= 1'b1;
                  end
                  if (last_col) begin
                     col <= '0;
                     if (last_row) begin
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= DONE;
                     end else begin
                        row   <= row + 1'b1;
                        state <= EVEN_ROW;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign dbg_state     = state;
endmodule
